// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store bridge to word-wide DataMemory, sub-word stores via read-modify-write
module load_store_unit #(
  parameter int ADDR_LIMIT = 512,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  state_t            r_state;
  logic              r_uns, r_error;
  logic [1:0]        r_size;
  logic [DATA_W-1:0] r_addr, r_wdata, r_merged, r_rdata;
  logic              w_err;
  logic [4:0]        w_shift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load, w_lane_mask, w_merged;
  always_comb begin
    w_err = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0]) |
            ((req_size == 2'b10) & (req_addr[1:0] != 2'b00)) | (req_addr >= DATA_W'(ADDR_LIMIT));
    w_shift = {r_addr[1:0], 3'b000};
    w_byte = 8'(mem_rdata >> w_shift);
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load = (r_size == 2'b00) ? {{24{~r_uns & w_byte[7]}}, w_byte} :
             (r_size == 2'b01) ? {{16{~r_uns & w_half[15]}}, w_half} : mem_rdata;
    w_lane_mask = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
    w_merged = (mem_rdata & ~w_lane_mask) | ((r_wdata << w_shift) & w_lane_mask);
  end
  assign req_ready  = rst_n & (r_state == IDLE);
  assign resp_valid = r_state == RESP;
  assign resp_rdata = r_rdata;
  assign resp_error = r_error;
  assign mem_read   = (r_state == LOAD) | (r_state == RMW_RD);
  assign mem_write  = r_state == WRITE;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = mem_write ? ((r_size == 2'b10) ? r_wdata : r_merged) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_uns    <= 1'b0;
      r_error  <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merged <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_uns   <= req_unsigned;
          r_size  <= req_size;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_error <= w_err;
          r_rdata <= '0;
          r_state <= w_err ? RESP : !req_we ? LOAD : (req_size == 2'b10) ? WRITE : RMW_RD;
        end
        LOAD: begin
          r_rdata <= w_load;
          r_state <= RESP;
        end
        RMW_RD: begin
          r_merged <= w_merged;
          r_state  <= WRITE;
        end
        WRITE: r_state <= RESP;
        RESP: if (resp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit against a behavioural DataMemory
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:127];
  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
  int          n_memcyc = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic        seen = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_LIMIT(512), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_addr[8:2]] : 32'h0;
  always @(posedge clk) if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    n_cmp++;
    if ((mem_read && mem_write) || (!mem_write && mem_wdata !== 32'h0)) begin
      n_bad++;
      $display("FAIL mem_invariant: rd=%b wr=%b wdata=%h, required exclusive rd/wr and wdata 0 outside write", mem_read, mem_write, mem_wdata);
    end
    if (mem_read || mem_write) n_memcyc++;
    if (mem_read) rd_cyc = cyc;
    if (mem_write) begin
      n_wr++;
      wr_cyc = cyc;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (!resp_valid) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL resp_unexpected: rdata=%h err=%b, required no response", resp_rdata, resp_error);
      end else begin
        e = sb.pop_front();
        if (resp_rdata !== e.rdata) begin
          n_bad++;
          $display("FAIL resp_rdata: got %h, required %h", resp_rdata, e.rdata);
        end
        n_cmp++;
        if (resp_error !== e.err) begin
          n_bad++;
          $display("FAIL resp_error: got %b, required %b", resp_error, e.err);
        end
        n_cmp++;
        if (cyc - acc_cyc + 1 != e.lat) begin
          n_bad++;
          $display("FAIL resp_latency: got %0d, required %0d", cyc - acc_cyc + 1, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL req_ready_timeout: got 0, required 1 within 50 cycles");
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    sb.push_back('{er, ee, el});
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain_timeout: req_ready got 0, required 1 within 50 cycles");
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({req_ready, resp_valid, resp_error, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b rv=%b rd=%b wr=%b addr=%h, required all 0", req_ready, resp_valid, mem_read, mem_write, mem_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_word_store();
    int w0 = n_wr;
    issue(1, 2'b10, 0, 32'h10, 32'h89ABCDEF, 32'h0, 0, 2);
    drain();
    n_cmp++;
    if (n_wr - w0 != 1 || last_waddr !== 32'h10 || last_wdata !== 32'h89ABCDEF) begin
      n_bad++;
      $display("FAIL sw_mem_cycle: writes=%0d addr=%h data=%h, required 1 / 00000010 / 89abcdef", n_wr - w0, last_waddr, last_wdata);
    end
  endtask

  task automatic test_loads();
    issue(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFCD, 0, 2);
    issue(0, 2'b00, 1, 32'h11, 32'h0, 32'h000000CD, 0, 2);
    issue(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF89AB, 0, 2);
    issue(0, 2'b01, 1, 32'h12, 32'h0, 32'h000089AB, 0, 2);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h89ABCDEF, 0, 2);
    issue(0, 2'b00, 0, 32'h1FF, 32'h0, 32'hFFFFFF80, 0, 2);
    drain();
  endtask

  task automatic test_subword_store();
    issue(1, 2'b00, 0, 32'h12, 32'hDEADBE5A, 32'h0, 0, 3);
    drain();
    n_cmp++;
    if (rd_cyc - acc_cyc + 1 != 1 || wr_cyc - acc_cyc + 1 != 2 || last_wdata !== 32'h895ACDEF) begin
      n_bad++;
      $display("FAIL sb_rmw: rd_cycle=%0d wr_cycle=%0d wdata=%h, required 1 / 2 / 895acdef", rd_cyc - acc_cyc + 1, wr_cyc - acc_cyc + 1, last_wdata);
    end
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h895ACDEF, 0, 2);
    issue(1, 2'b01, 0, 32'h10, 32'hCAFE1234, 32'h0, 0, 3);
    drain();
    n_cmp++;
    if (last_wdata !== 32'h895A1234) begin
      n_bad++;
      $display("FAIL sh_rmw_wdata: got %h, required 895a1234", last_wdata);
    end
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h895A1234, 0, 2);
    drain();
  endtask

  task automatic test_errors();
    int m0 = n_memcyc;
    issue(0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1, 1);
    issue(1, 2'b01, 0, 32'h13, 32'hFFFF, 32'h0, 1, 1);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1);
    issue(0, 2'b10, 0, 32'h200, 32'h0, 32'h0, 1, 1);
    issue(1, 2'b10, 0, 32'h200, 32'h1, 32'h0, 1, 1);
    drain();
    n_cmp++;
    if (n_memcyc != m0) begin
      n_bad++;
      $display("FAIL err_mem_quiet: memory cycles got %0d, required 0", n_memcyc - m0);
    end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h895A1234, 0, 2);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h12; req_wdata = '0;
    sb.push_back('{32'h0000005A, 1'b0, 2});
    for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h895A1234 || resp_error !== 1'b0 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold: rv=%b rdata=%h err=%b rdy=%b, required 1 / 895a1234 / 0 / 0", resp_valid, resp_rdata, resp_error, req_ready);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: rv=%b rdy=%b, required 0 / 1", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_rmw();
    int w0 = n_wr;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, resp_valid, resp_error, mem_read, mem_write, resp_rdata, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: rdy=%b rv=%b rd=%b wr=%b addr=%h wdata=%h, required all 0", req_ready, resp_valid, mem_read, mem_write, mem_addr, mem_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem[4] !== 32'h895A1234 || n_wr != w0) begin
      n_bad++;
      $display("FAIL rst_mid_word: mem=%h writes=%0d, required 895a1234 / 0", mem[4], n_wr - w0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_ready: got %b, required 1", req_ready);
    end
    issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h895A1234, 0, 2);
    drain();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[127] = 32'h80000000;
    test_reset();
    test_word_store();
    test_loads();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_mid_rmw();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending responses, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the datapath's memory stage and DataMemory. It accepts one load/store request at a time from the core over a valid/ready handshake.
- It drives DataMemory's word-wide port (mem_read, mem_write, address, write_data) and consumes its read_data.
- Adds byte/halfword loads with sign/zero extension, byte/halfword stores via read-modify-write, alignment and range checking, and a registered response with backpressure.

Parameters:
- ADDR_LIMIT, 512: byte-address bound. Any access with an address of ADDR_LIMIT or above is an error.
- DATA_W, 32: data and address width. Fixed at 32; other values are not supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned, out-of-range or illegal size
- mem_read  out  1  to DataMemory.mem_read
- mem_write  out  1  to DataMemory.mem_write
- mem_addr  out  32  to DataMemory.address; word-aligned (bits [1:0] = 00)
- mem_wdata  out  32  to DataMemory.write_data
- mem_rdata  in  32  from DataMemory.read_data; combinational, valid in the same cycle as mem_read

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including req_ready.
  - mem_write drops immediately, so no write completes.
  - An in-flight request is discarded with no response.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP. Encoding is free.
- IDLE:
  - req_ready = 1 (when rst_n is high); mem_read = mem_write = 0.
  - A transfer occurs on a rising edge with req_valid & req_ready. At that edge the unit latches we, size, unsigned, addr and wdata.
  - Error check, in priority order:
    - size = 11.
    - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 00.
    - addr >= ADDR_LIMIT.
    - Any error: go to RESP with resp_error = 1 and rdata = 0. No memory cycle is issued.
  - No error, routed by request type:
    - Load: go to LOAD.
    - Word store: go to WRITE.
    - Byte or half store: go to RMW_RD.
- LOAD:
  - Outputs: mem_read = 1, mem_addr = {addr[31:2], 2'b00}.
  - At the edge, extract lanes from mem_rdata (little-endian; lane k = bits [8k+7:8k]):
    - Byte: lane addr[1:0].
    - Half: bits [15:0] when addr[1] = 0, bits [31:16] when addr[1] = 1.
    - Word: the whole word.
  - Extend per unsigned and register into resp_rdata. Go to RESP.
- RMW_RD:
  - Outputs: mem_read = 1 at the aligned address.
  - At the edge, register the merged word: mem_rdata with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Go to WRITE.
- WRITE:
  - Outputs: mem_write = 1, mem_read = 0, aligned mem_addr.
  - mem_wdata = wdata for a word store, or the merged word for a sub-word store.
  - DataMemory commits on this edge. Go to RESP with rdata = 0 and error = 0.
- RESP:
  - resp_valid = 1; resp_rdata and resp_error are held stable until resp_valid & resp_ready.
  - On the handshake, go to IDLE. There is no same-cycle re-accept: req_ready is 0 in RESP.
- mem_read and mem_write are never both 1. Neither is asserted outside LOAD, RMW_RD and WRITE.
- Latency from the accept edge to resp_valid, with resp_ready held high:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Byte or half store: 3 cycles.
  - Error: 1 cycle.
- mem_addr holds the last latched aligned address when idle. mem_wdata is 0 outside WRITE.

Test Plan:
- SW 0x89ABCDEF @0x10 -> one mem_write cycle with mem_addr 0x10 and mem_wdata 0x89ABCDEF; resp at accept+2 with error 0.
- Then LB @0x11 -> rdata 0xFFFFFFCD; LBU @0x11 -> 0x000000CD; LH @0x12 -> 0xFFFF89AB; LHU @0x12 -> 0x000089AB; LW @0x10 -> 0x89ABCDEF.
- SB 0x5A @0x12 -> mem_read at cycle 1, mem_write at cycle 2 with mem_wdata 0x895ACDEF; a following LW @0x10 returns 0x895ACDEF. SH 0x1234 @0x10 -> 0x895A1234.
- LW @0x12, SH @0x13, size 11, and LW @0x200 -> resp_error 1 and rdata 0 at accept+1; mem_read and mem_write never assert.
- Backpressure: hold resp_ready low for 3 cycles after resp_valid -> resp_valid, resp_rdata and resp_error stay stable; req_ready stays 0; req_valid held high is accepted only after the RESP handshake.
- Reset asserted during RMW_RD of SB @0x10 -> outputs go to 0 immediately, no mem_write pulse, word unchanged. After release, req_ready = 1 and LW @0x10 returns the pre-store value.
